mem_write_scoreboard: RTL
=========================

Name: mem_write_scoreboard

Overview:
Parametrised, synthesisable scoreboard that watches the CPU data-memory write port and checks an ordered sequence of expected (address, data, mask) writes. The expected table is loaded at run time, so one block serves every program test. It reports an error count, a run duration, first-error capture and a finish flag. It sits beside the data memory in the pipelined-MIPS test top and replaces per-program hard-coded answer ROMs.

Parameters:
ADDR_W, 30, word-address width of the monitored port
DATA_W, 32, data width of the monitored port
DEPTH, 16, expected-table entries; IDX_W = $clog2(DEPTH)
ERR_W, 8, error counter width
DUR_W, 16, duration counter width
TIMEOUT, 50000, run-cycle limit (only with MEMCHK_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
addr  in  ADDR_W  monitored write address
data  in  DATA_W  monitored write data
wen  in  1  monitored write enable; may stay high for several cycles during a D-cache stall
tbl_wen  in  1  table load strobe, honoured only in IDLE
tbl_idx  in  IDX_W  table entry index
tbl_addr  in  ADDR_W  expected address
tbl_data  in  DATA_W  expected data
tbl_mask  in  DATA_W  compare mask; 1 = bit is checked
num_checks  in  IDX_W+1  entries to check (0..DEPTH), sampled on start
start  in  1  one-cycle pulse; IDLE->RUN
error_num  out  ERR_W  mismatch count, saturating
duration  out  DUR_W  cycles spent in RUN, saturating
finish  out  1  high while in DONE
first_err_vld  out  1  at least one mismatch captured
first_err_idx  out  IDX_W  entry index of the first mismatch
first_err_data  out  DATA_W  data seen at the first mismatch
timeout  out  1  run ended by the watchdog

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. On reset: state=IDLE; cur=0; wen_q=0; table entries, all outputs and all counters cleared to 0. A reset in any state aborts the run immediately.
- Write event: ev = wen & ~wen_q. wen_q registers wen every cycle in every state. A write held high across a stall counts once. A write still high when start arrives is not an event.
- IDLE: tbl_wen writes entry tbl_idx on the clock edge. start latches num_checks into nchk and clears error_num, duration, first_err_*, timeout and cur. Next state is RUN. Events in IDLE are ignored.
- RUN: duration increments every cycle and saturates at all-ones. On ev with addr==exp_addr[cur], compare (data&mask[cur]) against (exp_data[cur]&mask[cur]). On mismatch, error_num increments (saturating at 2^ERR_W-1). If first_err_vld==0, capture idx=cur and data, and set first_err_vld. In both cases cur increments. Events with a non-matching addr are ignored. tbl_wen and start are ignored.
- RUN->DONE: when the registered cur equals nchk, evaluated every RUN cycle. This gives one cycle of latency after the last checked write. nchk=0 goes to DONE on the first RUN cycle with duration=1.
- DONE: finish=1; every output holds. Only reset leaves DONE.
- Simultaneous start and ev in IDLE: the event is dropped. Simultaneous tbl_wen and start: the table write takes effect, and the run uses the updated entry.
- num_checks>DEPTH is clamped to DEPTH.

Optional Feature:
MEMCHK_TIMEOUT_EN. When defined, a RUN that reaches duration==TIMEOUT goes to DONE with timeout=1, and error_num is incremented once, saturating. When undefined, there is no limit and the timeout output is tied 0.

Test Plan:
- Load 3 entries (addr 0/1/2, data -2/-6/-24, mask all-ones), num_checks=3, start, write the matching values -> finish=1, error_num=0, first_err_vld=0.
- Same table, write data -7 at addr 1 -> error_num=1, first_err_idx=1, first_err_data=-7.
- Hold wen high 4 cycles at addr 0 with data -2 (stall), then release -> cur advances by exactly 1, no error.
- Mask=0x0000FFFF on entry 0 expecting 0x1234, write 0xABCD1234 -> pass; an interleaved write to addr 30 -> ignored.
- num_checks=0, start -> finish on the next cycle, duration=1. Assert rst low mid-run -> all outputs 0 asynchronously, state IDLE.
- With MEMCHK_TIMEOUT_EN and TIMEOUT=20, num_checks=2, no writes -> finish=1, timeout=1, error_num=1, duration=20.

Source files
------------

// File: rtl/mem_write_scoreboard.sv
// mem_write_scoreboard: checks CPU data-memory writes against a run-time loaded table of (addr, data, mask) entries.
// Optional watchdog: define MEMCHK_TIMEOUT_EN to end a run after TIMEOUT cycles.
module mem_write_scoreboard #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int ERR_W   = 8,
    parameter int DUR_W   = 16,
    parameter int TIMEOUT = 50000,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              tbl_wen,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic [DATA_W-1:0] tbl_mask,
    input  logic [IDX_W:0]    num_checks,
    input  logic              start,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic              finish,
    output logic              first_err_vld,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic              timeout
);
`ifdef MEMCHK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] exp_addr_q [DEPTH];
    logic [DATA_W-1:0] exp_data_q [DEPTH];
    logic [DATA_W-1:0] mask_q [DEPTH];
    logic wen_q;
    logic [IDX_W:0] cur_q, cur_d, nchk_q, nchk_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [DUR_W-1:0] dur_q, dur_d, dur_inc;
    logic fev_q, fev_d, to_q, to_d;
    logic [IDX_W-1:0] fidx_q, fidx_d, cur_idx;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic ev, go, run, all_done, tmo, tmo_hit, hit, miss, bump;
    // Write-event detect and run control terms
    always_comb begin
        ev       = wen & ~wen_q;
        go       = (state_q == IDLE) && start;
        run      = (state_q == RUN);
        cur_idx  = cur_q[IDX_W-1:0];
        all_done = (cur_q == nchk_q);
        dur_inc  = &dur_q ? dur_q : dur_q + 1'b1;
        tmo      = TMO_EN && (dur_inc == DUR_W'(TIMEOUT));
        tmo_hit  = run && !all_done && tmo;
        hit      = run && ev && !all_done && !tmo && (addr == exp_addr_q[cur_idx]);
        miss     = hit && (((data ^ exp_data_q[cur_idx]) & mask_q[cur_idx]) != '0);
        bump     = miss || tmo_hit;
    end
    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end
    // Next-state logic
    always_comb begin
        state_d = go ? RUN : (run && (all_done || tmo)) ? DONE : state_q;
    end
    // Counter and first-error next values
    always_comb begin
        cur_d   = go ? '0 : hit ? cur_q + 1'b1 : cur_q;
        nchk_d  = go ? ((num_checks > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : num_checks) : nchk_q;
        err_d   = go ? '0 : (bump && !(&err_q)) ? err_q + 1'b1 : err_q;
        dur_d   = go ? '0 : run ? dur_inc : dur_q;
        fev_d   = go ? 1'b0 : miss ? 1'b1 : fev_q;
        fidx_d  = go ? '0 : (miss && !fev_q) ? cur_idx : fidx_q;
        fdata_d = go ? '0 : (miss && !fev_q) ? data : fdata_q;
        to_d    = go ? 1'b0 : tmo_hit ? 1'b1 : to_q;
    end
    // Datapath registers; the table is writable only while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            cur_q   <= '0;
            nchk_q  <= '0;
            err_q   <= '0;
            dur_q   <= '0;
            fev_q   <= 1'b0;
            fidx_q  <= '0;
            fdata_q <= '0;
            to_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                exp_addr_q[i] <= '0;
                exp_data_q[i] <= '0;
                mask_q[i]     <= '0;
            end
        end else begin
            wen_q   <= wen;
            cur_q   <= cur_d;
            nchk_q  <= nchk_d;
            err_q   <= err_d;
            dur_q   <= dur_d;
            fev_q   <= fev_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
            to_q    <= to_d;
            if (state_q == IDLE && tbl_wen) begin
                exp_addr_q[tbl_idx] <= tbl_addr;
                exp_data_q[tbl_idx] <= tbl_data;
                mask_q[tbl_idx]     <= tbl_mask;
            end
        end
    end
    // Outputs
    always_comb begin
        error_num      = err_q;
        duration       = dur_q;
        finish         = (state_q == DONE);
        first_err_vld  = fev_q;
        first_err_idx  = fidx_q;
        first_err_data = fdata_q;
        timeout        = to_q;
    end
endmodule
